// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use bubble insertion.
// Optional event counters are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [RW-1:0] id_dst,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_shamt,
  input  logic [5:0]    id_alu_fun,
  input  logic          id_alu_sign,
  input  logic          id_alusrc_a,
  input  logic          id_alusrc_b,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          stall_in,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_dst,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_dst,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [5:0]    alu_fun,
  output logic          alu_sign,
  output logic          ex_valid,
  output logic [RW-1:0] ex_dst,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic [DW-1:0] ex_store_data,
  output logic          load_use_stall
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]   perf_bubble_cnt,
  output logic [31:0]   perf_flush_cnt
`endif
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs_addr;
    logic [RW-1:0] rt_addr;
    logic [RW-1:0] dst;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [4:0]    shamt;
    logic [5:0]    fun;
    logic          sign;
    logic          alusrc_a;
    logic          alusrc_b;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
  } stage_t;

  stage_t ex_q, id_s;
  logic [DW-1:0] fwd_rs, fwd_rt;

  // EX/MEM is the younger producer, so it is checked first; $0 never forwards.
  function automatic logic [DW-1:0] fwd_sel(
    input logic [RW-1:0] addr, input logic [DW-1:0] data,
    input logic em_we, input logic [RW-1:0] em_dst, input logic [DW-1:0] em_res,
    input logic mw_we, input logic [RW-1:0] mw_dst, input logic [DW-1:0] mw_res);
    if (em_we && em_dst != '0 && em_dst == addr)      return em_res;
    else if (mw_we && mw_dst != '0 && mw_dst == addr) return mw_res;
    else                                              return data;
  endfunction

  always_comb begin
    fwd_rs = fwd_sel(ex_q.rs_addr, ex_q.rs_data, exmem_reg_write, exmem_dst, exmem_result,
                     memwb_reg_write, memwb_dst, memwb_result);
    fwd_rt = fwd_sel(ex_q.rt_addr, ex_q.rt_data, exmem_reg_write, exmem_dst, exmem_result,
                     memwb_reg_write, memwb_dst, memwb_result);
  end

  always_comb begin
    id_s           = '0;
    id_s.valid     = id_valid;
    id_s.rs_addr   = id_rs_addr;
    id_s.rt_addr   = id_rt_addr;
    id_s.dst       = id_dst;
    id_s.rs_data   = id_rs_data;
    id_s.rt_data   = id_rt_data;
    id_s.imm       = id_imm;
    id_s.shamt     = id_shamt;
    id_s.fun       = id_alu_fun;
    id_s.sign      = id_alu_sign;
    id_s.alusrc_a  = id_alusrc_a;
    id_s.alusrc_b  = id_alusrc_b;
    id_s.reg_write = id_reg_write & id_valid;
    id_s.mem_read  = id_mem_read  & id_valid;
    id_s.mem_write = id_mem_write & id_valid;
  end

  assign load_use_stall = ~stall_in & id_valid & ex_q.valid & ex_q.mem_read &
                          (ex_q.dst != '0) &
                          ((ex_q.dst == id_rs_addr) | (ex_q.dst == id_rt_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ex_q <= '0;
    else if (flush)          ex_q <= '0;
    else if (stall_in) begin
      // Refresh so a MEM/WB value retiring during the hold is kept.
      ex_q.rs_data <= fwd_rs;
      ex_q.rt_data <= fwd_rt;
    end
    else if (load_use_stall) ex_q <= '0;
    else                     ex_q <= id_s;
  end

  assign alu_a         = ex_q.alusrc_a ? {{(DW-5){1'b0}}, ex_q.shamt} : fwd_rs;
  assign alu_b         = ex_q.alusrc_b ? ex_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_fun       = ex_q.fun;
  assign alu_sign      = ex_q.sign;
  assign ex_valid      = ex_q.valid;
  assign ex_dst        = ex_q.dst;
  assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
  assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
  assign ex_mem_write  = ex_q.valid & ex_q.mem_write;

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (!flush && load_use_stall) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage; sits directly upstream of the EX-stage ALU and drives its a, b, fun and sign inputs.
- Captures decoded operands each cycle and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, inserts a bubble, and honours downstream hold and branch flush.

Parameters:
- DW, 32, datapath width
- RW, 5, register-address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs_addr, id_rt_addr  in  RW  source register numbers
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_dst  in  RW  destination register
- id_imm  in  DW  immediate, already sign- or zero-extended
- id_shamt  in  5  shift amount
- id_alu_fun  in  6  ALU function code, passed through
- id_alu_sign  in  1  signed-overflow enable, passed through
- id_alusrc_a  in  1  1: operand A = zero-extended shamt
- id_alusrc_b  in  1  1: operand B = id_imm
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- stall_in  in  1  downstream hold
- flush  in  1  branch/jump redirect, kill ID→EX
- exmem_reg_write  in  1  EX/MEM writes a register
- exmem_dst  in  RW  EX/MEM destination
- exmem_result  in  DW  EX/MEM value
- memwb_reg_write  in  1  MEM/WB writes a register
- memwb_dst  in  RW  MEM/WB destination
- memwb_result  in  DW  MEM/WB value
- alu_a, alu_b  out  DW  ALU operands
- alu_fun  out  6  ALU function
- alu_sign  out  1  ALU sign enable
- ex_valid  out  1  EX holds a real instruction
- ex_dst  out  RW  destination
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  control bits; forced 0 when ex_valid = 0
- ex_store_data  out  DW  forwarded rt value
- load_use_stall  out  1  combinational; ID/IF must hold

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0.
  - ex_valid = 0, all control bits 0, alu_fun = 6'b000000, stored data 0.
  - alu_a, alu_b and ex_store_data therefore read 0.
- load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_dst != 0) & (ex_dst == id_rs_addr | ex_dst == id_rt_addr). It is masked to 0 while stall_in = 1.
- Register update priority on each clock edge:
  1. flush: load a bubble (valid and all control bits 0).
  2. stall_in: hold contents. Stored rs/rt data are refreshed with their forwarded value each cycle, so a MEM/WB result that retires during the hold is not lost.
  3. load_use_stall: load a bubble.
  4. Otherwise: capture all id_* inputs. ex_valid = id_valid; control bits are ANDed with id_valid.
- Forwarding (combinational, on stored rs/rt):
  - Source is EX/MEM if exmem_reg_write & exmem_dst != 0 & exmem_dst == addr.
  - Else MEM/WB under the same rule.
  - Else the stored data.
  - EX/MEM wins when both match. Register 0 is never forwarded.
- Operand selection:
  - alu_a = alusrc_a ? {27'b0, shamt} : fwd_rs.
  - alu_b = alusrc_b ? imm : fwd_rt.
  - ex_store_data = fwd_rt always.
- Latency: one cycle ID→EX. Forwarding adds no cycle; a load-use hazard costs exactly one bubble.
- A bubble presents alu_fun = 0, operands 0 and control bits 0.
- flush and load_use_stall in the same cycle: bubble loaded; ID is held by the stall but discarded by the fetch redirect.
- rst_n deassertion mid-stream: the first edge after release performs a normal capture.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined: adds outputs perf_bubble_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_bubble_cnt increments on each edge that loads a load-use bubble.
  - perf_flush_cnt increments on each edge where flush is taken.
  - Both wrap 0xFFFFFFFF→0 and are cleared by rst_n.
- Undefined: neither ports nor registers exist; all other behaviour is identical.

Test Plan:
- Add with no hazard: rs=$1=5, rt=$2=7, fun=000000. Next cycle alu_a=5, alu_b=7, ex_valid=1.
- EX/MEM forward: EX/MEM writes $1=0x20 and MEM/WB writes $1=0x10, both matching rs=$1. alu_a=0x20 (EX/MEM priority); with exmem_reg_write=0, alu_a=0x10.
- Register 0 guard: exmem_dst=0, exmem_result=0xDEAD, rs=$0 with rf data 0. alu_a=0.
- Load-use: lw $3 in EX, ID uses rt=$3. load_use_stall=1 for one cycle, then ex_valid=0 bubble. Next edge captures with MEM/WB-forwarded load data 0x1234 on alu_b.
- Hold with retire: stall_in=1 for 3 cycles while memwb writes rs=$4=0xABCD then retires. After release, alu_a=0xABCD.
- Flush vs stall: flush=1 and stall_in=1 together. Bubble loaded, ex_reg_write=0. Under ID_EX_PERF_CNT_EN, perf_flush_cnt goes 0→1.
